// File: rtl/i2c_reg_seq.sv
// Register-access sequencer in front of a byte-level I2C master: turns one host
// command (1-4 byte register write, or register read via repeated start) into master byte transfers.
module i2c_reg_seq #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int MAX_LEN        = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_rnw,
    input  logic [6:0]           cmd_dev_addr,
    input  logic [7:0]           cmd_reg_addr,
    input  logic [1:0]           cmd_len,
    input  logic [8*MAX_LEN-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [8*MAX_LEN-1:0] rsp_rdata,
    output logic [1:0]           rsp_err,
    output logic                 i2c_enable,
    output logic [6:0]           i2c_slv_addr,
    output logic                 i2c_rnw,
    output logic [7:0]           i2c_data_wr,
    input  logic                 i2c_busy,
    input  logic [7:0]           i2c_rd_data,
    input  logic                 i2c_nack
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, RESP} state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t               state, state_next;
    logic                 busy_prev;
    logic                 rise, fall, active, timeout, accept, capture;
    logic [2:0]           rise_cnt, fall_cnt, rise_next, fall_next, total;
    logic [1:0]           wr_idx, rd_idx;
    logic                 rnw_q;
    logic [1:0]           len_q;
    logic [8*MAX_LEN-1:0] wdata_q;
    logic [TW-1:0]        to_cnt;

    assign rise      = i2c_busy & ~busy_prev;
    assign fall      = ~i2c_busy & busy_prev;
    assign active    = (state == RUN) || (state == DRAIN);
    assign accept    = cmd_valid & cmd_ready;
    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // Total master bytes: the register pointer plus cmd_len+1 data bytes.
    assign total     = {1'b0, len_q} + 3'd2;
    assign rise_next = rise_cnt + 3'd1;
    assign fall_next = fall_cnt + 3'd1;
    assign wr_idx    = 2'(rise_next - 3'd1);
    assign rd_idx    = 2'(fall_next - 3'd2);

    // The watchdog cannot expire on a cycle that carries a busy edge.
    assign timeout = active && !rise && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Read bytes arrive on falls 2..total; after any NACK the data is meaningless.
    assign capture = fall && rnw_q && !i2c_nack && (rsp_err == 2'b00) &&
                     (fall_next >= 3'd2) && ((fall_next - 3'd2) <= {1'b0, len_q});

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_next = state;
        case (state)
            IDLE:  if (cmd_valid) state_next = RUN;
            RUN: begin
                if (timeout)                       state_next = RESP;
                else if (rise && rise_next == total) state_next = DRAIN;
                else if (fall && i2c_nack)         state_next = DRAIN;
            end
            DRAIN: if (timeout || fall) state_next = RESP;
            RESP:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy_prev    <= 1'b0;
            rise_cnt     <= '0;
            fall_cnt     <= '0;
            to_cnt       <= '0;
            rnw_q        <= 1'b0;
            len_q        <= '0;
            wdata_q      <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 2'b00;
            i2c_enable   <= 1'b0;
            i2c_slv_addr <= '0;
            i2c_rnw      <= 1'b0;
            i2c_data_wr  <= '0;
        end else begin
            state     <= state_next;
            busy_prev <= i2c_busy;
            case (state)
                IDLE: begin
                    if (accept) begin
                        rnw_q        <= cmd_rnw;
                        len_q        <= cmd_len;
                        wdata_q      <= cmd_wdata;
                        i2c_slv_addr <= cmd_dev_addr;
                        i2c_rnw      <= 1'b0;
                        i2c_data_wr  <= cmd_reg_addr;
                        i2c_enable   <= 1'b1;
                        rsp_rdata    <= '0;
                        rsp_err      <= 2'b00;
                        rise_cnt     <= '0;
                        fall_cnt     <= '0;
                        to_cnt       <= '0;
                    end
                end
                RUN, DRAIN: begin
                    to_cnt <= (rise || fall) ? '0 : to_cnt + TW'(1);
                    if (timeout) begin
                        i2c_enable <= 1'b0;
                        rsp_err    <= 2'b10;
                    end else begin
                        // On each rise the master has latched the current byte; stage the next one.
                        if (rise) begin
                            rise_cnt <= rise_next;
                            if (state == RUN) begin
                                if (rise_next == total)
                                    i2c_enable <= 1'b0;
                                else if (!rnw_q)
                                    i2c_data_wr <= wdata_q[8*wr_idx +: 8];
                                else if (rise_next == 3'd1)
                                    i2c_rnw <= 1'b1;
                            end
                        end
                        if (fall) begin
                            fall_cnt <= fall_next;
                            if (i2c_nack) begin
                                rsp_err    <= 2'b01;
                                i2c_enable <= 1'b0;
                            end
                            if (capture)
                                rsp_rdata[8*rd_idx +: 8] <= i2c_rd_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Self-checking bench for i2c_reg_seq: behavioural byte-level master/slave, a
// transaction-level reference model and a scoreboard checked by an independent monitor.
module tb_i2c_reg_seq;

    localparam int          TIMEOUT  = 2000;
    localparam int          BYTE_CYC = 18;
    localparam logic [6:0]  DEV      = 7'h50;
    localparam int          B_START  = 256;
    localparam int          B_SR     = 257;
    localparam int          B_STOP   = 258;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        bit          chk_bus;
        int          nbus;
        int          bus [12];
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_rnw;
    logic [6:0]  cmd_dev_addr;
    logic [7:0]  cmd_reg_addr;
    logic [1:0]  cmd_len;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        i2c_enable, i2c_rnw;
    logic [6:0]  i2c_slv_addr;
    logic [7:0]  i2c_data_wr;
    logic        i2c_busy, i2c_nack;
    logic [7:0]  i2c_rd_data;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int unsigned last_rise_cyc = 0;
    int unsigned rsp_cyc = 0;
    int          rsp_cnt = 0;
    int          xfer_bytes = 0;
    bit          stall = 1'b0;
    bit          abort = 1'b0;
    bit          prev_rsp = 1'b0;
    exp_t        exp_q [$];
    int          bus_log [$];
    logic [7:0]  slave_mem [256];
    logic [7:0]  ref_mem [256];
    logic [7:0]  ptr;
    int          wr_cnt;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_reg_seq #(.TIMEOUT_CYCLES(TIMEOUT), .MAX_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
        .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr),
        .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .i2c_enable(i2c_enable), .i2c_slv_addr(i2c_slv_addr), .i2c_rnw(i2c_rnw),
        .i2c_data_wr(i2c_data_wr), .i2c_busy(i2c_busy),
        .i2c_rd_data(i2c_rd_data), .i2c_nack(i2c_nack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    task automatic add(inout exp_t e, input int v);
        e.bus[e.nbus] = v;
        e.nbus++;
    endtask

    task automatic model(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [1:0] len, input logic [31:0] wd, output exp_t e);
        logic [7:0] a;
        e.rdata = '0; e.err = 2'b00; e.chk_bus = 1'b0; e.nbus = 0;
        for (int i = 0; i < 12; i++) e.bus[i] = 0;
        if (stall) e.err = 2'b10;
        else if (dev != DEV) e.err = 2'b01;
        else begin
            e.chk_bus = 1'b1;
            add(e, B_START); add(e, int'({dev, 1'b0})); add(e, int'(rg));
            if (rnw) begin add(e, B_SR); add(e, int'({dev, 1'b1})); end
            for (int i = 0; i <= int'(len); i++) begin
                a = rg + 8'(i);
                if (rnw) begin
                    e.rdata[8*i +: 8] = ref_mem[a];
                    add(e, int'(ref_mem[a]));
                end else begin
                    ref_mem[a] = wd[8*i +: 8];
                    add(e, int'(wd[8*i +: 8]));
                end
            end
            add(e, B_STOP);
        end
    endtask

    // ---------------- behavioural byte-level master + slave ----------------
    task automatic bfm_wait(input int n, output bit ab);
        ab = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (abort) begin ab = 1'b1; return; end
        end
    endtask

    task automatic addr_phase(input logic [6:0] a, input logic rw);
        bus_log.push_back(int'({a, rw}));
        if (a != DEV) i2c_nack = 1'b1;
        wr_cnt = 0;
    endtask

    task automatic run_transfer();
        logic [6:0] a;
        logic       rw;
        logic [7:0] d;
        bit         ab;
        a = i2c_slv_addr; rw = i2c_rnw; d = i2c_data_wr;
        i2c_nack = 1'b0; xfer_bytes = 0;
        bus_log.push_back(B_START);
        i2c_busy = 1'b1; last_rise_cyc = cyc;
        addr_phase(a, rw);
        forever begin
            if (stall) begin
                for (int i = 0; i < 4*TIMEOUT && i2c_enable; i++) @(negedge clk);
                i2c_busy = 1'b0;
                return;
            end
            bfm_wait(BYTE_CYC, ab);
            if (ab) begin i2c_busy = 1'b0; i2c_nack = 1'b0; return; end
            if (!rw) begin
                bus_log.push_back(int'(d));
                if (a == DEV) begin
                    if (wr_cnt == 0) ptr = d;
                    else begin slave_mem[ptr] = d; ptr = ptr + 8'd1; end
                end
                wr_cnt++;
            end else begin
                i2c_rd_data = (a == DEV) ? slave_mem[ptr] : 8'hFF;
                if (a == DEV) ptr = ptr + 8'd1;
                bus_log.push_back(int'(i2c_rd_data));
            end
            xfer_bytes++;
            i2c_busy = 1'b0;
            if (!i2c_enable) begin
                bus_log.push_back(B_STOP);
                bfm_wait(2, ab);
                return;
            end
            if ({i2c_slv_addr, i2c_rnw} != {a, rw}) begin
                a = i2c_slv_addr; rw = i2c_rnw; d = i2c_data_wr;
                bfm_wait(2, ab);
                if (ab) begin i2c_nack = 1'b0; return; end
                bus_log.push_back(B_SR);
                addr_phase(a, rw);
            end else begin
                d = i2c_data_wr;
            end
            bfm_wait(1, ab);
            if (ab) begin i2c_nack = 1'b0; return; end
            i2c_busy = 1'b1; last_rise_cyc = cyc;
        end
    endtask

    initial begin : master_bfm
        i2c_busy = 1'b0; i2c_rd_data = '0; i2c_nack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && i2c_enable && !abort) run_transfer();
        end
    end

    // ---------------- response monitor ----------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                rsp_cnt++;
                rsp_cyc = cyc;
                check("rsp_single_pulse", 32'(prev_rsp), 32'd0);
                check("rsp_enable_low", 32'(i2c_enable), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_rsp: got rsp_valid err=%0d expected no response", rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    if (e.chk_bus) begin
                        check("bus_len", 32'(bus_log.size()), 32'(e.nbus));
                        for (int i = 0; i < e.nbus && i < bus_log.size(); i++)
                            check("bus_item", 32'(bus_log[i]), 32'(e.bus[i]));
                    end else if (e.err == 2'b01) begin
                        check("nack_stop_seen", 32'(bus_log.size() > 0 && bus_log[bus_log.size()-1] == B_STOP), 32'd1);
                    end
                end
                bus_log.delete();
            end
            prev_rsp = rst_n && rsp_valid;
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [1:0] len, input logic [31:0] wd, input bit hold,
                         input bit expect_rsp);
        exp_t e;
        int   n;
        cmd_rnw = rnw; cmd_dev_addr = dev; cmd_reg_addr = rg; cmd_len = len; cmd_wdata = wd;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20000) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout: got cmd_ready=0 expected 1 within 20000 cycles");
            cmd_valid = 1'b0;
            return;
        end
        model(rnw, dev, rg, len, wd, e);
        if (expect_rsp) exp_q.push_back(e);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3*TIMEOUT) begin @(negedge clk); n++; end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin : stimulus
        int   saved;
        int   n;
        bit   early;
        logic [31:0] v;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_dev_addr = '0;
        cmd_reg_addr = '0; cmd_len = '0; cmd_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            slave_mem[i] = v[7:0]; ref_mem[i] = v[7:0];
        end
        for (int i = 0; i < 4; i++) begin
            slave_mem[8'h20 + i] = 8'(8'h11 * (i + 1));
            ref_mem[8'h20 + i]   = 8'(8'h11 * (i + 1));
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_enable", 32'(i2c_enable), 32'd0);
        check("reset_outputs", {rsp_rdata[7:0], 6'(rsp_err), i2c_slv_addr, i2c_rnw, i2c_data_wr, 2'b00}, 32'd0);

        issue(1'b0, DEV, 8'h10, 2'd1, 32'h0000BEEF, 1'b0, 1'b1);
        wait_rsp("write_rsp");
        issue(1'b1, DEV, 8'h20, 2'd3, 32'h0, 1'b0, 1'b1);
        wait_rsp("read_rsp");
        issue(1'b0, 7'h3C, 8'h10, 2'd2, 32'h00C0FFEE, 1'b0, 1'b1);
        wait_rsp("nack_write_rsp");
        issue(1'b1, 7'h3C, 8'h20, 2'd1, 32'h0, 1'b0, 1'b1);
        wait_rsp("nack_read_rsp");

        stall = 1'b1;
        issue(1'b0, DEV, 8'h30, 2'd0, 32'h5A, 1'b0, 1'b1);
        wait_rsp("timeout_rsp");
        check("timeout_latency", 32'((rsp_cyc - last_rise_cyc >= TIMEOUT) &&
                                      (rsp_cyc - last_rise_cyc <= TIMEOUT + 1)), 32'd1);
        stall = 1'b0;
        repeat (4) @(negedge clk);

        issue(1'b1, DEV, 8'h20, 2'd3, 32'h0, 1'b0, 1'b0);
        n = 0;
        while (xfer_bytes < 2 && n < 2000) begin @(negedge clk); n++; end
        check("reset_mid_read_reached", 32'(xfer_bytes >= 2), 32'd1);
        saved = rsp_cnt;
        abort = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        check("midreset_enable", 32'(i2c_enable), 32'd0);
        check("midreset_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        bus_log.delete();
        repeat (50) @(negedge clk);
        check("midreset_no_rsp", 32'(rsp_cnt), 32'(saved));
        issue(1'b0, DEV, 8'h40, 2'd3, 32'h12345678, 1'b0, 1'b1);
        wait_rsp("post_reset_write_rsp");

        issue(1'b0, DEV, 8'h50, 2'd1, 32'h0000A55A, 1'b1, 1'b1);
        cmd_rnw = 1'b1; cmd_dev_addr = DEV; cmd_reg_addr = 8'h50; cmd_len = 2'd1;
        saved = rsp_cnt; early = 1'b0; n = 0;
        while (rsp_cnt == saved && n < 3*TIMEOUT) begin
            if (cmd_ready) early = 1'b1;
            @(negedge clk); n++;
        end
        check("b2b_ready_low", 32'(early), 32'd0);
        issue(1'b1, DEV, 8'h50, 2'd1, 32'h0, 1'b0, 1'b1);
        wait_rsp("b2b_second_rsp");

        for (int t = 0; t < 30; t++) begin
            issue(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0) ? 7'h3C : DEV,
                  8'($urandom), 2'($urandom_range(0, 3)), $urandom, 1'b0, 1'b1);
            wait_rsp("rand_rsp");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
